ahb_bram_ctrl: RTL and testbench

AHB-Lite slave that is the bus-side initiator for the team's byte-writable, single-port block RAM (synchronous read, 1-cycle latency, 4-bit byte write enables). It sits between the Cortex-M0 bus matrix and one RAM instance serving code or data memory. It converts AHB address/data phases into RAM address, write-data and byte-enable strobes. It resolves the single-port conflict when a read follows a write, and returns ERROR for illegal sizes and misaligned accesses.

---
 rtl/ahb_bram_ctrl_if.sv | 24 ++
 rtl/ahb_bram_ctrl.sv | 120 ++++++++++++
 tb/tb_ahb_bram_ctrl.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/ahb_bram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the block RAM controller.
// The master modport is the bus matrix side; the slave modport is the controller.
interface ahb_bram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic [2:0]  HSIZE;
    logic        HWRITE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HSIZE, HWRITE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_bram_ctrl.sv
// AHB-Lite to single-port byte-writable block RAM bridge.
// Reads issue in the address phase (zero wait); writes land in the data phase.
// A read that follows a write directly waits one cycle so it sees the new data.
// Illegal sizes / misaligned accesses get a two-cycle ERROR and never touch RAM.
module ahb_bram_ctrl #(
    parameter int ADDR_WIDTH = 14
) (
    input  logic                  HCLK,
    input  logic                  HRESET,
    ahb_bram_ctrl_if.slave        ahb,
    output logic [ADDR_WIDTH-1:0] bram_addr,
    output logic [31:0]           bram_wdata,
    output logic [3:0]            bram_we,
    input  logic [31:0]           bram_rdata
);

    typedef enum logic [2:0] {
        S_IDLE, S_RD, S_WR, S_RDW, S_ERR1, S_ERR2
    } state_t;

    state_t                state, state_nxt;
    logic                  accept, illegal, rd_acc, wr_acc;
    logic [3:0]            lanes;
    logic [3:0]            we_q;        // lanes of the write in its data phase
    logic [ADDR_WIDTH-1:0] haddr_word;
    logic [ADDR_WIDTH-1:0] wr_addr, rd_addr, addr_hold;
    logic                  hreadyout_q, hresp_q;

    // Upper HADDR bits alias; HTRANS[0] (SEQ vs NONSEQ) is irrelevant here.
    logic unused_bits;
    assign unused_bits = ^{ahb.HADDR[31:ADDR_WIDTH+2], ahb.HTRANS[0]};

    assign haddr_word = ahb.HADDR[ADDR_WIDTH+1:2];
    assign accept     = ahb.HSEL & ahb.HTRANS[1] & ahb.HREADY;
    assign rd_acc     = accept & ~illegal & ~ahb.HWRITE;
    assign wr_acc     = accept & ~illegal &  ahb.HWRITE;

    // Size / alignment legality of the transfer in its address phase.
    always_comb begin
        illegal = 1'b0;
        case (ahb.HSIZE)
            3'd0:    illegal = 1'b0;
            3'd1:    illegal = ahb.HADDR[0];
            3'd2:    illegal = (ahb.HADDR[1:0] != 2'b00);
            default: illegal = 1'b1;
        endcase
    end

    // Byte-lane strobes for a write in its address phase.
    always_comb begin
        lanes = 4'b0000;
        case (ahb.HSIZE)
            3'd0:    lanes = 4'b0001 << ahb.HADDR[1:0];
            3'd1:    lanes = ahb.HADDR[1] ? 4'b1100 : 4'b0011;
            default: lanes = 4'b1111;
        endcase
    end

    // Next state; RDW and ERR1 stall the bus so nothing is accepted there.
    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_RDW:  state_nxt = S_RD;
            S_ERR1: state_nxt = S_ERR2;
            default: begin
                if (accept && illegal)
                    state_nxt = S_ERR1;
                else if (rd_acc)
                    state_nxt = (state == S_WR) ? S_RDW : S_RD;
                else if (wr_acc)
                    state_nxt = S_WR;
                else
                    state_nxt = S_IDLE;
            end
        endcase
    end

    // RAM address: the write owns the port in WR, a deferred read in RDW,
    // otherwise a fresh read goes straight through in its address phase.
    always_comb begin
        bram_addr = addr_hold;
        if (state == S_WR)
            bram_addr = wr_addr;
        else if (state == S_RDW)
            bram_addr = rd_addr;
        else if (rd_acc)
            bram_addr = haddr_word;
    end

    // Reset gates the strobe so a write caught in reset is dropped.
    assign bram_we       = (HRESET || state != S_WR) ? 4'b0000 : we_q;
    assign bram_wdata    = ahb.HWDATA;
    assign ahb.HRDATA    = bram_rdata;
    assign ahb.HREADYOUT = hreadyout_q;
    assign ahb.HRESP     = hresp_q;

    // State register, registered bus responses and captured address-phase info.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state       <= S_IDLE;
            hreadyout_q <= 1'b1;
            hresp_q     <= 1'b0;
            we_q        <= 4'b0000;
            wr_addr     <= '0;
            rd_addr     <= '0;
            addr_hold   <= '0;
        end else begin
            state       <= state_nxt;
            hreadyout_q <= !(state_nxt == S_RDW || state_nxt == S_ERR1);
            hresp_q     <= (state_nxt == S_ERR1 || state_nxt == S_ERR2);
            we_q        <= (state_nxt == S_WR) ? lanes : 4'b0000;
            addr_hold   <= bram_addr;
            if (wr_acc)
                wr_addr <= haddr_word;
            if (rd_acc)
                rd_addr <= haddr_word;
        end
    end

endmodule

// File: tb/tb_ahb_bram_ctrl.sv
// Cycle-table bench for ahb_bram_ctrl with a behavioural byte-writable RAM.
// Each row is one clock: inputs driven just after posedge, outputs checked at negedge.
module tb_ahb_bram_ctrl;
    localparam int AW = 14;

    logic          HCLK = 1'b0;
    logic          HRESET;
    logic [AW-1:0] bram_addr;
    logic [31:0]   bram_wdata;
    logic [3:0]    bram_we;
    logic [31:0]   bram_rdata;

    ahb_bram_ctrl_if bus ();

    // Single slave on the bus: HREADY follows our own HREADYOUT.
    assign bus.HREADY = bus.HREADYOUT;

    ahb_bram_ctrl #(.ADDR_WIDTH(AW)) dut (
        .HCLK       (HCLK),
        .HRESET     (HRESET),
        .ahb        (bus.slave),
        .bram_addr  (bram_addr),
        .bram_wdata (bram_wdata),
        .bram_we    (bram_we),
        .bram_rdata (bram_rdata)
    );

    always #5 HCLK = ~HCLK;

    // Behavioural RAM: read-first, 1-cycle read latency, byte write enables.
    logic [31:0] mem [0:(1<<AW)-1];
    always @(posedge HCLK) begin
        for (int b = 0; b < 4; b++)
            if (bram_we[b]) mem[bram_addr][8*b +: 8] <= bram_wdata[8*b +: 8];
        bram_rdata <= mem[bram_addr];
    end

    typedef struct {
        logic        rst;
        logic        sel;
        logic [1:0]  trans;
        logic [31:0] addr;
        logic [2:0]  size;
        logic        write;
        logic [31:0] wdata;
        logic        exp_rdy;
        logic        exp_resp;
        logic [3:0]  exp_we;
        logic        chk_ba;
        logic [AW-1:0] exp_ba;
        logic        chk_rd;
        logic [31:0] exp_rd;
    } vec_t;

    localparam logic [1:0] ID = 2'b00, NS = 2'b10;

    vec_t tbl[$];
    int   checks = 0;
    int   failures = 0;

    task automatic add(input logic sel, input logic [1:0] trans, input logic [31:0] addr,
                       input logic [2:0] size, input logic write, input logic [31:0] wdata,
                       input logic rdy, input logic resp, input logic [3:0] we,
                       input logic cba, input logic [AW-1:0] ba,
                       input logic crd, input logic [31:0] rd);
        vec_t v;
        v.rst = 1'b0; v.sel = sel; v.trans = trans; v.addr = addr; v.size = size;
        v.write = write; v.wdata = wdata; v.exp_rdy = rdy; v.exp_resp = resp;
        v.exp_we = we; v.chk_ba = cba; v.exp_ba = ba; v.chk_rd = crd; v.exp_rd = rd;
        tbl.push_back(v);
    endtask

    task automatic chk(input string name, input int row, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s row %0d: got %h expected %h", name, row, act, exp);
        end
    endtask

    // One bus cycle: drive after posedge, compare at the following negedge.
    task automatic step(input vec_t v, input int row);
        @(posedge HCLK);
        #1;
        HRESET     = v.rst;
        bus.HSEL   = v.sel;
        bus.HTRANS = v.trans;
        bus.HADDR  = v.addr;
        bus.HSIZE  = v.size;
        bus.HWRITE = v.write;
        bus.HWDATA = v.wdata;
        @(negedge HCLK);
        chk("hreadyout", row, {31'd0, bus.HREADYOUT}, {31'd0, v.exp_rdy});
        chk("hresp", row, {31'd0, bus.HRESP}, {31'd0, v.exp_resp});
        chk("bram_we", row, {28'd0, bram_we}, {28'd0, v.exp_we});
        if (v.chk_ba) chk("bram_addr", row, {{(32-AW){1'b0}}, bram_addr}, {{(32-AW){1'b0}}, v.exp_ba});
        if (v.chk_rd) chk("hrdata", row, bus.HRDATA, v.exp_rd);
    endtask

    initial begin
        vec_t h;
        HRESET = 1'b1;
        bus.HSEL = 1'b0; bus.HTRANS = ID; bus.HADDR = '0;
        bus.HSIZE = 3'd2; bus.HWRITE = 1'b0; bus.HWDATA = '0;

        //   sel trans addr   sz w  wdata         rdy rsp we      cba ba  crd rdata
        // word write / read back
        add(1, NS, 32'h10, 2, 1, 32'h0,        1, 0, 4'b0000, 0, 0,  0, 0);            // 0
        add(0, ID, 32'h0,  2, 0, 32'hDEADBEEF, 1, 0, 4'b1111, 1, 4,  0, 0);            // 1
        add(1, NS, 32'h10, 2, 0, 32'h0,        1, 0, 4'b0000, 1, 4,  0, 0);            // 2
        add(0, ID, 32'h0,  2, 0, 32'h0,        1, 0, 4'b0000, 0, 0,  1, 32'hDEADBEEF); // 3
        // byte writes over a known word
        add(1, NS, 32'h20, 2, 1, 32'h0,        1, 0, 4'b0000, 0, 0,  0, 0);            // 4
        add(1, NS, 32'h21, 0, 1, 32'h11223344, 1, 0, 4'b1111, 1, 8,  0, 0);            // 5
        add(1, NS, 32'h23, 0, 1, 32'hAAAAAAAA, 1, 0, 4'b0010, 1, 8,  0, 0);            // 6
        add(0, ID, 32'h0,  2, 0, 32'h55555555, 1, 0, 4'b1000, 1, 8,  0, 0);            // 7
        add(1, NS, 32'h20, 2, 0, 32'h0,        1, 0, 4'b0000, 1, 8,  0, 0);            // 8
        add(0, ID, 32'h0,  2, 0, 32'h0,        1, 0, 4'b0000, 0, 0,  1, 32'h5522AA44); // 9
        // write immediately followed by read of the same word
        add(1, NS, 32'h40, 2, 1, 32'h0,        1, 0, 4'b0000, 0, 0,  0, 0);            // 10
        add(1, NS, 32'h40, 2, 0, 32'h12345678, 1, 0, 4'b1111, 1, 16, 0, 0);            // 11
        add(0, ID, 32'h0,  2, 0, 32'h0,        0, 0, 4'b0000, 1, 16, 0, 0);            // 12
        add(0, ID, 32'h0,  2, 0, 32'h0,        1, 0, 4'b0000, 0, 0,  1, 32'h12345678); // 13
        // illegal accesses, the later ones accepted during ERR2
        add(1, NS, 32'h42, 2, 0, 32'h0,        1, 0, 4'b0000, 0, 0,  0, 0);            // 14
        add(0, ID, 32'h0,  2, 0, 32'h0,        0, 1, 4'b0000, 0, 0,  0, 0);            // 15
        add(1, NS, 32'h43, 1, 1, 32'h0,        1, 1, 4'b0000, 0, 0,  0, 0);            // 16
        add(0, ID, 32'h0,  2, 0, 32'hFFFFFFFF, 0, 1, 4'b0000, 0, 0,  0, 0);            // 17
        add(1, NS, 32'h40, 3, 1, 32'hFFFFFFFF, 1, 1, 4'b0000, 0, 0,  0, 0);            // 18
        add(0, ID, 32'h0,  2, 0, 32'hFFFFFFFF, 0, 1, 4'b0000, 0, 0,  0, 0);            // 19
        add(1, NS, 32'h40, 2, 0, 32'h0,        1, 1, 4'b0000, 0, 0,  0, 0);            // 20
        // IDLE transfer and unselected NONSEQ write do nothing
        add(1, ID, 32'h40, 2, 1, 32'h0,        1, 0, 4'b0000, 0, 0,  1, 32'h12345678); // 21
        add(0, NS, 32'h40, 2, 1, 32'h0,        1, 0, 4'b0000, 0, 0,  0, 0);            // 22
        add(0, ID, 32'h0,  2, 0, 32'h0,        1, 0, 4'b0000, 0, 0,  0, 0);            // 23
        add(1, NS, 32'h40, 2, 0, 32'h0,        1, 0, 4'b0000, 1, 16, 0, 0);            // 24
        add(0, ID, 32'h0,  2, 0, 32'h0,        1, 0, 4'b0000, 0, 0,  1, 32'h12345678); // 25
        // seed 0x80 for the reset case
        add(1, NS, 32'h80, 2, 1, 32'h0,        1, 0, 4'b0000, 0, 0,  0, 0);            // 26
        add(0, ID, 32'h0,  2, 0, 32'hCAFEF00D, 1, 0, 4'b1111, 1, 32, 0, 0);            // 27
        add(0, ID, 32'h0,  2, 0, 32'h0,        1, 0, 4'b0000, 0, 0,  0, 0);            // 28

        // Reset state
        repeat (2) @(posedge HCLK);
        @(negedge HCLK);
        chk("rst_hreadyout", -1, {31'd0, bus.HREADYOUT}, 32'd1);
        chk("rst_hresp", -1, {31'd0, bus.HRESP}, 32'd0);
        chk("rst_bram_we", -1, {28'd0, bram_we}, 32'd0);

        foreach (tbl[i]) step(tbl[i], i);

        // Reset landing in the WR cycle of a write to 0x80 drops the write
        h = tbl[26];
        step(h, 100);
        h = tbl[28]; h.wdata = 32'h0BADBEEF; h.rst = 1'b1;
        h.exp_we = 4'b0000; h.chk_ba = 1'b0;
        step(h, 101);
        h = tbl[24]; h.addr = 32'h80; h.chk_ba = 1'b1; h.exp_ba = 32;
        step(h, 102);
        h = tbl[28]; h.chk_rd = 1'b1; h.exp_rd = 32'hCAFEF00D;
        step(h, 103);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
